rvfi_retire_checker: RTL
========================

Name: rvfi_retire_checker

Overview:
- Clocked, multi-channel RVFI retirement checker for the formal and simulation benches.
- Sits between a core's RVFI port and per-channel ISA spec model instances. Checks per-instruction spec agreement, as the single-cycle decoder harness did.
- Also checks cross-instruction properties over NRET retirement channels: order continuity, PC continuity and channel packing.
- Captures the first failure and reports it through a sticky error record and counters.

Parameters:
- NRET, 1, number of retirement channels per cycle (1..4)
- XLEN, 32, data/PC width
- CNT_W, 32, width of retired/checked counters
- SKIP_SYSTEM, 1, when 1 the spec check is skipped for insn[6:0]==7'b1110011 (channel still counts as retired)

Ports:
- clock  in  1  sole clock
- reset_n  in  1  asynchronous active-low reset
- rvfi_valid  in  NRET  per-channel retire strobe
- rvfi_order  in  NRET*64  per-channel retirement index
- rvfi_insn  in  NRET*32  instruction word
- rvfi_trap  in  NRET  trap flag
- rvfi_pc_rdata  in  NRET*XLEN  PC of instruction
- rvfi_pc_wdata  in  NRET*XLEN  next PC
- rvfi_rd_addr  in  NRET*5  destination register
- rvfi_rd_wdata  in  NRET*XLEN  destination value
- spec_valid  in  NRET  spec model recognised insn
- spec_trap  in  NRET  spec model expects trap
- spec_rd_addr  in  NRET*5  spec destination
- spec_rd_wdata  in  NRET*XLEN  spec destination value
- spec_pc_wdata  in  NRET*XLEN  spec next PC
- err  out  1  sticky failure flag
- err_code  out  3  first failure cause
- err_chan  out  2  channel of first failure
- err_order  out  64  rvfi_order of first failing retirement
- retired_cnt  out  CNT_W  total valid retirements
- checked_cnt  out  CNT_W  retirements that passed the spec check
- busy  out  1  high in RUN state

Behaviour:
- All outputs registered; every result appears one cycle after the sampling edge. Reset forces state IDLE and all outputs to 0.
- FSM states:
  - IDLE: no retirement seen yet.
  - RUN: tracking.
  - FAIL: sticky until reset.
- FSM transitions:
  - IDLE -> RUN on the first cycle with any rvfi_valid bit.
  - RUN -> FAIL on any detected error.
  - IDLE -> FAIL directly if the first retiring cycle itself has an error.
- Per-cycle checks on valid channels, scanned low to high; the first failing channel wins. Within a channel, cause priority:
  - 1 GAP: valid channels must be packed from 0; valid[i]=1 with valid[i-1]=0 is an error on channel i.
  - 2 ORDER: order[i] must equal exp_order + i. exp_order is loaded from order[0] on the IDLE->RUN cycle, so the first cycle is self-consistent. It advances by popcount(valid) each cycle.
  - 3 PC: pc_rdata[i] must equal last_pc_wdata. For channel i>0 in the same cycle, last_pc_wdata is pc_wdata[i-1]. This check is not applied to channel 0 of the first retiring cycle.
  - 4 SPEC_VALID: when rvfi_trap=0 and the channel is not skipped, require spec_valid=1 and spec_trap=0.
  - 5 RD: rd_addr must equal spec_rd_addr. When rd_addr==0, rd_wdata must be 0; otherwise it must equal spec_rd_wdata.
  - 6 PCW: pc_wdata must equal spec_pc_wdata.
  - Checks 5 and 6 apply only where check 4 applies.
- Trapping or skipped retirements: checks 1-3 still apply; checked_cnt is not incremented.
- On the first error:
  - Latch err=1, err_code, err_chan, and err_order = that channel's rvfi_order.
  - retired_cnt and checked_cnt still include channels below err_chan in that cycle. They freeze from then on.
  - Later errors never overwrite the record.
- Counters saturate at all-ones; no wrap.
- Cycles with valid==0 change nothing.
- Reset asserted mid-run clears state immediately and asynchronously. The next retirement after release is treated as first-ever.
- Channel bits at or above NRET do not exist. err_chan is 0 when NRET==1.

Test Plan:
- NRET=1: 3 ADDI retirements, orders 0,1,2, PCs 0x0->0x4->0x8, spec matching -> retired_cnt=3, checked_cnt=3, err=0, busy=1.
- NRET=2: cycle A valid=2'b11, orders 10,11; cycle B valid=2'b01, order 13 -> err=1, err_code=2, err_chan=0, err_order=13, retired_cnt=2.
- NRET=2: valid=2'b10 on the first cycle -> err_code=1, err_chan=1, state FAIL, retired_cnt=0.
- NRET=1: second retirement has pc_rdata=0x10 while previous pc_wdata=0x8 -> err_code=3. A subsequent correct retirement leaves err_order and counters unchanged.
- NRET=1, SKIP_SYSTEM=1: ECALL (0x00000073) with spec_valid=0, then an ADDI with rd_addr=0 and rd_wdata=5 -> ECALL counted retired but not checked; ADDI gives err_code=5.
- Mid-run reset_n pulse low for 1 cycle -> all outputs 0 asynchronously. The next retirement with order 100 is accepted without an ORDER error.

Source files
------------

// File: rtl/rvfi_retire_checker.sv
// Multi-channel RVFI retirement checker: compares each retirement against the
// per-channel spec model, checks order/PC continuity and channel packing, and
// records the first failure.
`timescale 1ns/1ps
module rvfi_retire_checker #(
  parameter int NRET        = 1,
  parameter int XLEN        = 32,
  parameter int CNT_W       = 32,
  parameter int SKIP_SYSTEM = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NRET-1:0]      rvfi_valid,
  input  logic [NRET*64-1:0]   rvfi_order,
  input  logic [NRET*32-1:0]   rvfi_insn,
  input  logic [NRET-1:0]      rvfi_trap,
  input  logic [NRET*XLEN-1:0] rvfi_pc_rdata,
  input  logic [NRET*XLEN-1:0] rvfi_pc_wdata,
  input  logic [NRET*5-1:0]    rvfi_rd_addr,
  input  logic [NRET*XLEN-1:0] rvfi_rd_wdata,
  input  logic [NRET-1:0]      spec_valid,
  input  logic [NRET-1:0]      spec_trap,
  input  logic [NRET*5-1:0]    spec_rd_addr,
  input  logic [NRET*XLEN-1:0] spec_rd_wdata,
  input  logic [NRET*XLEN-1:0] spec_pc_wdata,
  output logic                 err,
  output logic [2:0]           err_code,
  output logic [1:0]           err_chan,
  output logic [63:0]          err_order,
  output logic [CNT_W-1:0]     retired_cnt,
  output logic [CNT_W-1:0]     checked_cnt,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FAIL = 2'd2
  } state_e;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [2:0] CODE_NONE  = 3'd0;
  localparam logic [2:0] CODE_GAP   = 3'd1;
  localparam logic [2:0] CODE_ORDER = 3'd2;
  localparam logic [2:0] CODE_PC    = 3'd3;
  localparam logic [2:0] CODE_SPECV = 3'd4;
  localparam logic [2:0] CODE_RD    = 3'd5;
  localparam logic [2:0] CODE_PCW   = 3'd6;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W+1)'(b);
    if (sum[CNT_W]) begin
      sat_add = '1;
    end else begin
      sat_add = sum[CNT_W-1:0];
    end
  endfunction

  state_e            state_r, state_next_s;
  logic [63:0]       exp_order_r, exp_order_next_s;
  logic [XLEN-1:0]   last_pc_r, last_pc_next_s;
  logic              err_r, err_next_s;
  logic [2:0]        err_code_r, err_code_next_s;
  logic [1:0]        err_chan_r, err_chan_next_s;
  logic [63:0]       err_order_r, err_order_next_s;
  logic [CNT_W-1:0]  retired_r, retired_next_s;
  logic [CNT_W-1:0]  checked_r, checked_next_s;
  logic              busy_r, busy_next_s;

  logic              first_s, any_valid_s;
  logic [63:0]       base_order_s;
  logic              scan_fail_s;
  logic [2:0]        scan_code_s, chan_code_s;
  logic [1:0]        scan_chan_s;
  logic [63:0]       scan_order_s;
  logic [2:0]        ret_inc_s, chk_inc_s, pop_s;
  logic [XLEN-1:0]   pc_chain_s;
  logic              prev_valid_s, applies_s, rd_bad_s;
  logic              unused_insn_s;

  assign unused_insn_s = ^rvfi_insn;
  assign first_s       = (state_r == ST_IDLE);
  assign any_valid_s   = |rvfi_valid;
  // The first retiring cycle seeds the expected order from its own channel 0.
  assign base_order_s  = first_s ? rvfi_order[63:0] : exp_order_r;

  // Scan channels low to high; the first failing channel stops counting.
  always_comb begin
    scan_fail_s  = 1'b0;
    scan_code_s  = CODE_NONE;
    scan_chan_s  = 2'd0;
    scan_order_s = 64'd0;
    ret_inc_s    = 3'd0;
    chk_inc_s    = 3'd0;
    pop_s        = 3'd0;
    pc_chain_s   = last_pc_r;
    prev_valid_s = 1'b1;
    chan_code_s  = CODE_NONE;
    applies_s    = 1'b0;
    rd_bad_s     = 1'b0;
    for (int i = 0; i < NRET; i++) begin
      applies_s = !rvfi_trap[i] &&
                  !((SKIP_SYSTEM != 0) && (rvfi_insn[i*32 +: 7] == OPC_SYSTEM));
      rd_bad_s  = (rvfi_rd_addr[i*5 +: 5] != spec_rd_addr[i*5 +: 5]) ||
                  ((rvfi_rd_addr[i*5 +: 5] == 5'd0) ?
                     (rvfi_rd_wdata[i*XLEN +: XLEN] != '0) :
                     (rvfi_rd_wdata[i*XLEN +: XLEN] != spec_rd_wdata[i*XLEN +: XLEN]));
      if (!prev_valid_s) begin
        chan_code_s = CODE_GAP;
      end else if (rvfi_order[i*64 +: 64] != base_order_s + 64'(i)) begin
        chan_code_s = CODE_ORDER;
      end else if (!(first_s && (i == 0)) && (rvfi_pc_rdata[i*XLEN +: XLEN] != pc_chain_s)) begin
        chan_code_s = CODE_PC;
      end else if (applies_s && (!spec_valid[i] || spec_trap[i])) begin
        chan_code_s = CODE_SPECV;
      end else if (applies_s && rd_bad_s) begin
        chan_code_s = CODE_RD;
      end else if (applies_s && (rvfi_pc_wdata[i*XLEN +: XLEN] != spec_pc_wdata[i*XLEN +: XLEN])) begin
        chan_code_s = CODE_PCW;
      end else begin
        chan_code_s = CODE_NONE;
      end
      if (rvfi_valid[i] && !scan_fail_s) begin
        if (chan_code_s != CODE_NONE) begin
          scan_fail_s  = 1'b1;
          scan_code_s  = chan_code_s;
          scan_chan_s  = 2'(i);
          scan_order_s = rvfi_order[i*64 +: 64];
        end else begin
          ret_inc_s  = ret_inc_s + 3'd1;
          chk_inc_s  = applies_s ? (chk_inc_s + 3'd1) : chk_inc_s;
          pc_chain_s = rvfi_pc_wdata[i*XLEN +: XLEN];
        end
      end else begin
        pc_chain_s = pc_chain_s;
      end
      pop_s        = rvfi_valid[i] ? (pop_s + 3'd1) : pop_s;
      prev_valid_s = rvfi_valid[i];
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_valid_s) begin
          state_next_s = scan_fail_s ? ST_FAIL : ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (any_valid_s && scan_fail_s) begin
          state_next_s = ST_FAIL;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_FAIL: state_next_s = ST_FAIL;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Next values of the tracking state and the registered outputs.
  always_comb begin
    exp_order_next_s = exp_order_r;
    last_pc_next_s   = last_pc_r;
    err_next_s       = err_r;
    err_code_next_s  = err_code_r;
    err_chan_next_s  = err_chan_r;
    err_order_next_s = err_order_r;
    retired_next_s   = retired_r;
    checked_next_s   = checked_r;
    busy_next_s      = (state_next_s == ST_RUN);
    if ((state_r != ST_FAIL) && any_valid_s) begin
      retired_next_s = sat_add(retired_r, ret_inc_s);
      checked_next_s = sat_add(checked_r, chk_inc_s);
      if (scan_fail_s) begin
        err_next_s       = 1'b1;
        err_code_next_s  = scan_code_s;
        err_chan_next_s  = scan_chan_s;
        err_order_next_s = scan_order_s;
      end else begin
        exp_order_next_s = base_order_s + 64'(pop_s);
        last_pc_next_s   = pc_chain_s;
      end
    end else begin
      retired_next_s = retired_r;
      checked_next_s = checked_r;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exp_order_r <= 64'd0;
      last_pc_r   <= '0;
      err_r       <= 1'b0;
      err_code_r  <= 3'd0;
      err_chan_r  <= 2'd0;
      err_order_r <= 64'd0;
      retired_r   <= '0;
      checked_r   <= '0;
      busy_r      <= 1'b0;
    end else begin
      exp_order_r <= exp_order_next_s;
      last_pc_r   <= last_pc_next_s;
      err_r       <= err_next_s;
      err_code_r  <= err_code_next_s;
      err_chan_r  <= err_chan_next_s;
      err_order_r <= err_order_next_s;
      retired_r   <= retired_next_s;
      checked_r   <= checked_next_s;
      busy_r      <= busy_next_s;
    end
  end

  assign err         = err_r;
  assign err_code    = err_code_r;
  assign err_chan    = err_chan_r;
  assign err_order   = err_order_r;
  assign retired_cnt = retired_r;
  assign checked_cnt = checked_r;
  assign busy        = busy_r;

endmodule
